// File: rtl/we_run_sequencer.sv
// we_run_sequencer
// Hardware-timed measurement loop for WETOP in the 512 kHz weClk domain:
// configure SPI, settle, run task, gap, repeat for n_runs, with done-edge
// supervision and timeout.
//
// Ports:
//   clk_512k        sole clock; rst synchronous active-high
//   start / abort   one-cycle control pulses from the host
//   n_runs, cfg_every, settle_cyc, gap_cyc, timeout_cyc
//                   sequence configuration, latched on an accepted start
//   done_spi / done_task
//                   WETOP completion (level or pulse, rising edge used)
//   trigger_config / trigger_task
//                   one-cycle trigger pulses to WETOP
//   busy, run_idx, seq_done, err_timeout, err_cfg, state_o
//                   status readback
module we_run_sequencer #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned RUN_W = 16
) (
  input  logic             clk_512k,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [RUN_W-1:0] n_runs,
  input  logic             cfg_every,
  input  logic [CNT_W-1:0] settle_cyc,
  input  logic [CNT_W-1:0] gap_cyc,
  input  logic [CNT_W-1:0] timeout_cyc,
  input  logic             done_spi,
  input  logic             done_task,
  output logic             trigger_config,
  output logic             trigger_task,
  output logic             busy,
  output logic [RUN_W-1:0] run_idx,
  output logic             seq_done,
  output logic             err_timeout,
  output logic             err_cfg,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CFG       = 3'd1,
    ST_CFG_WAIT  = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_TASK      = 3'd4,
    ST_TASK_WAIT = 3'd5,
    ST_GAP       = 3'd6,
    ST_DONE      = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0] run_idx_q, run_idx_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_cfg_q, err_cfg_d;
  logic             spi_prev_q, task_prev_q;

  // Shadow copies of the configuration, frozen for the whole sequence.
  logic [RUN_W-1:0] n_runs_q, n_runs_d;
  logic             cfg_every_q, cfg_every_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;

  logic             spi_edge, task_edge;
  logic             timeout_hit;
  logic [CNT_W-1:0] cnt_inc;
  logic [RUN_W-1:0] run_next;
  state_t           next_run_st;

  assign spi_edge  = done_spi  & ~spi_prev_q;
  assign task_edge = done_task & ~task_prev_q;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign run_next  = run_idx_q + RUN_W'(1);
  // Comparing against timeout-1 means the counter never needs to exceed
  // timeout_cyc, so full-scale values work without an extra bit.
  assign timeout_hit = (timeout_q != '0) && (cnt_q == timeout_q - CNT_W'(1));
  assign next_run_st = cfg_every_q ? ST_CFG : ST_TASK;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    run_idx_d     = run_idx_q;
    err_timeout_d = err_timeout_q;
    err_cfg_d     = err_cfg_q;
    n_runs_d      = n_runs_q;
    cfg_every_d   = cfg_every_q;
    settle_d      = settle_q;
    gap_d         = gap_q;
    timeout_d     = timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          n_runs_d      = n_runs;
          cfg_every_d   = cfg_every;
          settle_d      = settle_cyc;
          gap_d         = gap_cyc;
          timeout_d     = timeout_cyc;
          run_idx_d     = '0;
          err_timeout_d = 1'b0;
          err_cfg_d     = (n_runs == '0);
          if (n_runs != '0) state_d = ST_CFG;
        end
      end
      ST_CFG: begin
        cnt_d   = '0;
        state_d = ST_CFG_WAIT;
      end
      ST_CFG_WAIT: begin
        if (spi_edge) begin
          cnt_d   = '0;
          state_d = (settle_q != '0) ? ST_SETTLE : ST_TASK;
        end else if (timeout_hit) begin
          err_timeout_d = 1'b1;
          state_d       = ST_DONE;
        end else if (timeout_q != '0) begin
          cnt_d = cnt_inc;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == settle_q - CNT_W'(1)) state_d = ST_TASK;
        else                               cnt_d   = cnt_inc;
      end
      ST_TASK: begin
        cnt_d   = '0;
        state_d = ST_TASK_WAIT;
      end
      ST_TASK_WAIT: begin
        if (task_edge) begin
          run_idx_d = run_next;
          cnt_d     = '0;
          if (run_next == n_runs_q) state_d = ST_DONE;
          else if (gap_q != '0)     state_d = ST_GAP;
          else                      state_d = next_run_st;
        end else if (timeout_hit) begin
          err_timeout_d = 1'b1;
          state_d       = ST_DONE;
        end else if (timeout_q != '0) begin
          cnt_d = cnt_inc;
        end
      end
      ST_GAP: begin
        if (cnt_q == gap_q - CNT_W'(1)) state_d = next_run_st;
        else                            cnt_d   = cnt_inc;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides whatever the state logic decided, including a done
    // edge or timeout landing in the same cycle: progress and flags hold.
    if (abort && state_q != ST_IDLE) begin
      state_d       = ST_IDLE;
      run_idx_d     = run_idx_q;
      err_timeout_d = err_timeout_q;
    end
  end

  always_ff @(posedge clk_512k) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      run_idx_q     <= '0;
      err_timeout_q <= 1'b0;
      err_cfg_q     <= 1'b0;
      spi_prev_q    <= 1'b0;
      task_prev_q   <= 1'b0;
      n_runs_q      <= '0;
      cfg_every_q   <= 1'b0;
      settle_q      <= '0;
      gap_q         <= '0;
      timeout_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      run_idx_q     <= run_idx_d;
      err_timeout_q <= err_timeout_d;
      err_cfg_q     <= err_cfg_d;
      spi_prev_q    <= done_spi;
      task_prev_q   <= done_task;
      n_runs_q      <= n_runs_d;
      cfg_every_q   <= cfg_every_d;
      settle_q      <= settle_d;
      gap_q         <= gap_d;
      timeout_q     <= timeout_d;
    end
  end

  assign trigger_config = (state_q == ST_CFG);
  assign trigger_task   = (state_q == ST_TASK);
  assign seq_done       = (state_q == ST_DONE);
  assign busy           = (state_q != ST_IDLE);
  assign run_idx        = run_idx_q;
  assign err_timeout    = err_timeout_q;
  assign err_cfg        = err_cfg_q;
  assign state_o        = state_q;

endmodule
